// File: rtl/riscv_uart_rx_fifo_pkg.sv
// Shared UART definitions: APB register offsets, status/control bit positions
// and the APB access decoder used by the RX FIFO.
package uart_p;

  localparam logic [11:0] A_RXD  = 12'h010;
  localparam logic [11:0] A_STS  = 12'h014;
  localparam logic [11:0] A_CTRL = 12'h018;

  localparam int unsigned STS_NEMPTY  = 0;
  localparam int unsigned STS_FULL    = 1;
  localparam int unsigned STS_OVR     = 2;
  localparam int unsigned STS_FERR    = 3;
  localparam int unsigned STS_PERR    = 4;
  localparam int unsigned STS_IRQ_EN  = 5;
  localparam int unsigned STS_CNT_LSB = 8;

  localparam int unsigned CTRL_FLUSH  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    AccNone,
    AccRxdRd,
    AccStsRd,
    AccCtrlWr
  } acc_e;

  function automatic acc_e decode_acc(input logic access, input logic write,
                                      input logic [11:0] off);
    acc_e a;
    a = AccNone;
    if (access) begin
      if (!write && off == A_RXD) a = AccRxdRd;
      else if (!write && off == A_STS) a = AccStsRd;
      else if (write && off == A_CTRL) a = AccCtrlWr;
    end
    return a;
  endfunction

endpackage

// File: rtl/riscv_uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush wins over push and pop.
// Storage is not reset, only pointers and count.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/riscv_uart_rx_fifo.sv
// UART receive FIFO with APB register front-end: data pop, sticky error
// status, flush/irq-enable control and a registered level interrupt.
module riscv_uart_rx_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DBITS = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [DBITS-1:0] rx_data,
  input  logic             rx_frame_err,
  input  logic             rx_parity_err,
  input  logic             sel,
  input  logic             enable,
  input  logic             write,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata,
  output logic             irq
);
  import uart_p::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  acc_e             acc;
  logic             rd_rxd, rd_sts, wr_ctrl, flush, pop, push, space;
  logic             set_ovr, set_ferr, set_perr;
  logic [DBITS-1:0] dout;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic [XLEN-1:0]  sts, rdata_q, rdata_d;
  logic             ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic             irq_en_q, irq_en_d, irq_q, irq_d;
  logic             unused_bits;

  assign unused_bits = ^{addr[XLEN-1:12], wdata[XLEN-1:2]};

  assign acc     = decode_acc(sel & enable, write, addr[11:0]);
  assign rd_rxd  = (acc == AccRxdRd);
  assign rd_sts  = (acc == AccStsRd);
  assign wr_ctrl = (acc == AccCtrlWr);
  assign flush   = wr_ctrl & wdata[CTRL_FLUSH];

  assign pop   = rd_rxd & ~empty;
  assign space = ~full | pop;
  assign push  = rx_valid & ~rx_frame_err & space & ~flush;

  // A flush discards the incoming character silently, so no flag is raised.
  assign set_ovr  = rx_valid & ~space & ~flush;
  assign set_ferr = rx_valid & rx_frame_err & ~flush;
  assign set_perr = rx_valid & rx_parity_err & ~rx_frame_err & ~flush;

  riscv_sync_fifo #(
    .WIDTH (DBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sts                        = '0;
    sts[STS_NEMPTY]            = ~empty;
    sts[STS_FULL]              = full;
    sts[STS_OVR]               = ovr_q;
    sts[STS_FERR]              = ferr_q;
    sts[STS_PERR]              = perr_q;
    sts[STS_IRQ_EN]            = irq_en_q;
    sts[STS_CNT_LSB +: CW]     = count;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_rxd) rdata_d = empty ? '0 : XLEN'(dout);
    else if (rd_sts) rdata_d = sts;

    // Status read clears old flags but a flag raised this cycle survives.
    ovr_d  = (ovr_q  & ~rd_sts) | set_ovr;
    ferr_d = (ferr_q & ~rd_sts) | set_ferr;
    perr_d = (perr_q & ~rd_sts) | set_perr;

    irq_en_d = wr_ctrl ? wdata[CTRL_IRQ_EN] : irq_en_q;
    irq_d    = irq_en_q & (~empty | ovr_q | ferr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_riscv_uart_rx_fifo.sv
// Scoreboard bench for riscv_uart_rx_fifo: characters queued on push,
// popped and compared on A_RXD reads; status and irq checked against constants.
module tb_riscv_uart_rx_fifo;
  import uart_p::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_frame_err = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic        sel = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  riscv_uart_rx_fifo #(
    .XLEN  (32),
    .DBITS (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .sel           (sel),
    .enable        (enable),
    .write         (write),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .irq           (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the queue model mirrors push/pop/flush behaviour.
  task automatic drive(input bit v, input logic [7:0] d, input bit fe, input bit pe,
                       input bit acc, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          is_pop, is_flush;
    rx_valid      = v;
    rx_data       = d;
    rx_frame_err  = fe;
    rx_parity_err = pe;
    sel           = acc;
    enable        = acc;
    write         = wr;
    addr          = {20'h0, a};
    wdata         = wd;
    is_pop   = acc && !wr && (a == A_RXD);
    is_flush = acc && wr && (a == A_CTRL) && wd[0];
    exp_rd   = '0;
    if (is_pop && exp_q.size() > 0) exp_rd = {24'h0, exp_q.pop_front()};
    if (is_flush) exp_q.delete();
    else if (v && !fe && exp_q.size() < DEPTH) exp_q.push_back(d);
    step();
    rx_valid = 1'b0; rx_frame_err = 1'b0; rx_parity_err = 1'b0;
    sel = 1'b0; enable = 1'b0; write = 1'b0;
    if (is_pop) check_eq("rxd", rdata, exp_rd);
  endtask

  task automatic rx(input logic [7:0] d, input bit fe, input bit pe);
    drive(1'b1, d, fe, pe, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic rd_rxd();
    drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0, A_RXD, 32'h0);
  endtask

  task automatic rd_sts(input string tag, input logic [31:0] exp);
    drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0, A_STS, 32'h0);
    check_eq(tag, rdata, exp);
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    drive(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1, A_CTRL, v);
  endtask

  initial begin
    #1;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Two characters, status, pops, status.
    rx(8'h41, 1'b0, 1'b0);
    rx(8'h42, 1'b0, 1'b0);
    rd_sts("sts_two", 32'h0000_0201);
    rd_rxd();
    rd_rxd();
    rd_sts("sts_empty", 32'h0);

    // Overfill: the 17th character is dropped and flags overrun.
    for (int i = 0; i < 17; i++) rx(8'h60 + 8'(i), 1'b0, 1'b0);
    rd_sts("sts_ovr", 32'h0000_1007);
    rd_sts("sts_ovr_clr", 32'h0000_1003);

    // Push and pop together at full: no overrun, count stays 16.
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, A_RXD, 32'h0);
    rd_sts("sts_full_pp", 32'h0000_1003);
    for (int i = 0; i < DEPTH; i++) rd_rxd();
    rd_sts("sts_drained", 32'h0);

    // Frame error drops the character and raises irq one cycle later.
    wr_ctrl(32'h2);
    rx(8'hAA, 1'b1, 1'b0);
    check_eq("irq_lag", {31'h0, irq}, 32'h0);
    step();
    check_eq("irq_ferr", {31'h0, irq}, 32'h1);
    rd_sts("sts_ferr", 32'h0000_0028);
    step();
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
    rx(8'h33, 1'b0, 1'b1);
    step();
    check_eq("irq_nempty", {31'h0, irq}, 32'h1);
    rd_sts("sts_perr", 32'h0000_0131);
    rd_rxd();
    wr_ctrl(32'h0);

    // Flush coinciding with an incoming character.
    for (int i = 0; i < 5; i++) rx(8'h10 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, A_CTRL, 32'h1);
    rd_sts("sts_flush", 32'h0);
    rd_rxd();

    // Asynchronous reset in the middle of a burst.
    wr_ctrl(32'h2);
    for (int i = 0; i < 7; i++) rx(8'h80 + 8'(i), 1'b0, 1'b0);
    rd_sts("sts_pre_rst", 32'h0000_0721);
    check_eq("irq_pre_rst", {31'h0, irq}, 32'h1);
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rdata", rdata, 32'h0);
    check_eq("async_irq", {31'h0, irq}, 32'h0);
    rx_valid = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    rd_rxd();
    rd_sts("sts_post_rst", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_uart_rx_fifo.md
RISCV_UART_RX_FIFO -- requirements
Module: riscv_uart_rx_fifo

Interface
REQ-001 SHALL have parameter XLEN, default 32, APB data/address width.
REQ-002 SHALL have parameter DBITS, default 8, UART character width.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle pulse: character completed by the UART RX FSM.
REQ-007 SHALL have port rx_data, input, DBITS, received character, qualified by rx_valid.
REQ-008 SHALL have port rx_frame_err, input, 1, stop bit sampled 0, qualified by rx_valid.
REQ-009 SHALL have port rx_parity_err, input, 1, parity mismatch, qualified by rx_valid.
REQ-010 SHALL have ports sel, enable, write, input, 1 each, APB access qualifiers; access = sel & enable.
REQ-011 SHALL have ports addr, wdata, input, XLEN each; rdata, output, XLEN.
REQ-012 SHALL have port irq, output, 1, level interrupt.

Function
REQ-013 SHALL decode addr[11:0]: A_RXD 0x010 read/pop, A_STS 0x014 read status, A_CTRL 0x018 write control; other offsets are no-ops and leave rdata unchanged.
REQ-014 SHALL register rdata: rdata updates on the edge of a read access; value is visible the following cycle.
REQ-015 SHALL, for an A_RXD read, return the head character zero-extended and pop it in the same cycle; reading an empty FIFO returns 0 with no pointer change.
REQ-016 SHALL, for an A_STS read, return: bit0 not-empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err, bit5 irq_en, bits[15:8] occupancy count; other bits 0.
REQ-017 SHALL clear the sticky flags overrun, frame_err and parity_err on the cycle after an A_STS read; a flag raised in the same cycle as that read SHALL survive.
REQ-018 SHALL, on an A_CTRL write, apply bit0 as a self-clearing FIFO flush (pointers and count to 0, data not cleared) and store bit1 as irq_en.
REQ-019 SHALL push rx_data when rx_valid=1, rx_frame_err=0 and space is available.
REQ-020 SHALL treat space as available when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-021 SHALL drop the character and set overrun when rx_valid=1 and no space is available.
REQ-022 SHALL drop the character and set frame_err when rx_valid=1 and rx_frame_err=1.
REQ-023 SHALL push the character and set parity_err when rx_valid=1 and rx_parity_err=1 (with rx_frame_err=0).
REQ-024 SHALL keep count unchanged on a simultaneous push and pop.
REQ-025 SHALL let a flush take priority over a simultaneous push or pop: the FIFO ends empty and the push is discarded with no flag set.
REQ-026 SHALL use read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, with count width $clog2(DEPTH)+1.
REQ-027 SHALL drive irq = irq_en & (not-empty | overrun | frame_err), registered, with a 1-cycle lag after the cause.

Reset
REQ-028 SHALL, while rst_n=0, force pointers, count, all sticky flags, irq_en, irq and rdata to 0.
REQ-029 SHALL abandon any in-flight push or pop when reset is asserted mid-operation; storage array contents are don't-care.

Structure
REQ-030 SHALL add the A_RXD, A_STS and A_CTRL address constants and the status/control bit-index constants to the shared uart_p package.
REQ-031 SHALL instantiate one sub-module, riscv_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, din, dout, count, full, empty); status, flags, APB decode and irq logic remain in the top level.

Verification
REQ-032 Push 0x41, 0x42 -> A_STS next cycle returns count=2, bit0=1; A_RXD reads return 0x41 then 0x42; then A_STS returns 0x0000.
REQ-033 Push 17 characters into an empty DEPTH=16 FIFO with no reads -> count=16, full=1, overrun=1; character 17 is absent; first A_STS read shows overrun, second shows 0.
REQ-034 At full, apply rx_valid (0x55) in the same cycle as an A_RXD read -> pop returns the oldest entry, 0x55 is stored, count stays 16, overrun stays 0.
REQ-035 Apply rx_valid with rx_frame_err=1 (0xAA) -> count unchanged, frame_err=1; with irq_en=1, irq asserts the next cycle.
REQ-036 Write A_CTRL=0x1 in the same cycle as rx_valid, with 5 entries stored -> count=0, bit0=0, no flags set.
REQ-037 Assert rst_n=0 asynchronously mid-burst at count=7 -> all outputs are 0 immediately; after release, A_RXD returns 0.
